// File: rtl/if_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_controller
// Purpose  : Instruction-fetch sequencer for a variable-latency instruction
//            memory with a req/ready handshake. Owns the fetch PC, keeps at
//            most one request outstanding, buffers returned words in a
//            2-entry queue and handles branch redirects, including redirects
//            that arrive while a request is still in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1        clock, rising edge
//   rst           in   1        synchronous active-high reset
//   freeze        in   1        downstream stall, head entry is not consumed
//   branch_taken  in   1        redirect fetch to branch_addr, flush queue
//   branch_addr   in   ADDR_W   redirect target
//   mem_req       out  1        request to instruction memory
//   mem_addr      out  ADDR_W   request address (held until mem_ready)
//   mem_ready     in   1        memory completes the current request
//   mem_rdata     in   INSTR_W  returned instruction word
//   valid_out     out  1        head entry presented
//   pc_out        out  ADDR_W   address of head instruction + PC_STEP
//   instruction   out  INSTR_W  head instruction word
//   busy          out  1        request outstanding or stale data pending
// ============================================================================
module if_fetch_controller #(
    parameter int unsigned            ADDR_W   = 32,
    parameter int unsigned            INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0,
    parameter int unsigned            PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               valid_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instruction,
    output logic               busy
);

    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(PC_STEP);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DROP  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   r_target;
    logic                r_mem_req;

    logic [ADDR_W-1:0]   r_q_pc    [2];
    logic [INSTR_W-1:0]  r_q_instr [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_count;

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_next_count;

    assign w_accept = r_mem_req & mem_ready;
    // Data returned in DROP or together with a branch belongs to the old path.
    assign w_push   = (r_state == ST_FETCH) & w_accept & ~branch_taken;
    assign w_pop    = valid_out & ~freeze & ~branch_taken;

    always_comb begin
        w_next_count = r_count;
        if (branch_taken) begin
            w_next_count = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_next_count = r_count + 2'd1;
                2'b01:   w_next_count = r_count - 2'd1;
                default: w_next_count = r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= RESET_PC;
            r_target   <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            // Queue side
            if (branch_taken) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_q_pc[r_wr_ptr]    <= r_fetch_pc + c_pc_step;
                    r_q_instr[r_wr_ptr] <= mem_rdata;
                    r_wr_ptr            <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
            r_count <= w_next_count;

            // Memory side
            if (r_mem_req & ~mem_ready) begin
                // Request in flight: address and req stay frozen. A branch
                // here can only be remembered until the stale data returns.
                r_mem_req <= 1'b1;
                if (branch_taken) begin
                    r_target <= branch_addr;
                    r_state  <= ST_DROP;
                end
            end else begin
                // Idle or request accepted this cycle. DROP always has a
                // request up, so reaching here in DROP means the stale word
                // has just been consumed. A live branch beats the target.
                if (branch_taken) begin
                    r_fetch_pc <= branch_addr;
                end else if (r_state == ST_DROP) begin
                    r_fetch_pc <= r_target;
                end else if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + c_pc_step;
                end
                r_state <= ST_FETCH;
                // Issue only when a slot is guaranteed free at response time;
                // the queue can only drain while the request is pending.
                r_mem_req <= (w_next_count < 2'd2);
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_fetch_pc;
    assign valid_out   = (r_count != 2'd0);
    assign pc_out      = valid_out ? r_q_pc[r_rd_ptr]    : '0;
    assign instruction = valid_out ? r_q_instr[r_rd_ptr] : '0;
    assign busy        = r_mem_req | (r_state == ST_DROP);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_controller
// Purpose  : Directed self-checking bench for if_fetch_controller. A small
//            memory responder returns addr ^ 0xA5A5_0000 after a selectable
//            number of wait cycles, or mem_ready is driven by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int wcnt  = 0;
    int wait_n = 0;
    bit auto_mem = 1'b1;

    if_fetch_controller #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .valid_out    (valid_out),
        .pc_out       (pc_out),
        .instruction  (instruction),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive this cycle's memory response, cross one
    // rising edge, return at the following negedge.
    task automatic step();
        logic acc;
        logic req_b;
        if (auto_mem) mem_ready = mem_req && (wcnt == wait_n);
        mem_rdata = mem_addr ^ 32'hA5A5_0000;
        req_b = mem_req;
        acc   = mem_req && mem_ready;
        @(posedge clk);
        if (rst || acc || !auto_mem) wcnt = 0;
        else if (req_b) wcnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        auto_mem = 1'b1; wait_n = 0; mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        wcnt = 0;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_pc",    pc_out,         32'd0);
        chk("rst_instr", instruction,    32'd0);
        chk("rst_req",   32'(mem_req),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);

        // ---------------- zero-wait streaming ----------------
        step();                                   // cycle 1
        chk("zw_c1_req",   32'(mem_req),   32'd1);
        chk("zw_c1_addr",  mem_addr,       32'h0);
        chk("zw_c1_valid", 32'(valid_out), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("zw_addr",  mem_addr,       32'(4 * (k - 1)));
            chk("zw_valid", 32'(valid_out), 32'd1);
            chk("zw_pc",    pc_out,         32'(4 * (k - 1)));
            chk("zw_instr", instruction,    32'(4 * (k - 2)) ^ 32'hA5A5_0000);
        end

        // ---------------- 3-cycle latency ----------------
        do_reset();
        wait_n = 2;
        step();                                   // cycle 1
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 3; c++) begin
                chk("lat_req",   32'(mem_req),   32'd1);
                chk("lat_addr",  mem_addr,       32'(4 * w));
                chk("lat_valid", 32'(valid_out), (c == 0 && w > 0) ? 32'd1 : 32'd0);
                if (c == 0 && w > 0) begin
                    chk("lat_pc",    pc_out,      32'(4 * w));
                    chk("lat_instr", instruction, 32'(4 * (w - 1)) ^ 32'hA5A5_0000);
                end
                step();
            end
        end

        // ---------------- freeze, zero-wait ----------------
        do_reset();
        freeze = 1'b1;
        for (int k = 0; k < 10; k++) step();      // cycle 10
        chk("frz_req",   32'(mem_req),   32'd0);
        chk("frz_busy",  32'(busy),      32'd0);
        chk("frz_valid", 32'(valid_out), 32'd1);
        chk("frz_pc",    pc_out,         32'h4);
        chk("frz_instr", instruction,    32'hA5A5_0000);
        chk("frz_addr",  mem_addr,       32'h8);
        freeze = 1'b0;
        step();                                   // cycle 11
        chk("rel_pc",    pc_out,         32'h8);
        chk("rel_instr", instruction,    32'hA5A5_0004);
        chk("rel_req",   32'(mem_req),   32'd1);
        chk("rel_addr",  mem_addr,       32'h8);
        step();                                   // cycle 12
        chk("rel2_pc",    pc_out,      32'hC);
        chk("rel2_instr", instruction, 32'hA5A5_0008);

        // ---------------- branch while request outstanding ----------------
        do_reset();
        for (int k = 0; k < 5; k++) step();       // cycle 5, request at 0x10
        chk("bo_addr0", mem_addr,       32'h10);
        chk("bo_pc0",   pc_out,         32'h10);
        auto_mem = 1'b0; mem_ready = 1'b0;
        branch_taken = 1'b1; branch_addr = 32'h100;
        step();                                   // cycle 6
        branch_taken = 1'b0; branch_addr = 32'h0;
        chk("bo_hold1",  mem_addr,       32'h10);
        chk("bo_req1",   32'(mem_req),   32'd1);
        chk("bo_valid1", 32'(valid_out), 32'd0);
        chk("bo_busy1",  32'(busy),      32'd1);
        step();                                   // cycle 7
        chk("bo_hold2",  mem_addr,       32'h10);
        chk("bo_valid2", 32'(valid_out), 32'd0);
        mem_ready = 1'b1;
        step();                                   // cycle 8
        auto_mem = 1'b1;
        chk("bo_newaddr", mem_addr,       32'h100);
        chk("bo_newreq",  32'(mem_req),   32'd1);
        chk("bo_valid3",  32'(valid_out), 32'd0);
        step();                                   // cycle 9
        chk("bo_valid4", 32'(valid_out), 32'd1);
        chk("bo_pc4",    pc_out,         32'h104);
        chk("bo_instr4", instruction,    32'hA5A5_0100);

        // ---------------- branch with ready, branches in DROP ----------------
        do_reset();
        step(); step();                           // cycle 2, request at 0x4
        branch_taken = 1'b1; branch_addr = 32'h80;
        step();                                   // cycle 3
        chk("bc_valid", 32'(valid_out), 32'd0);
        chk("bc_addr",  mem_addr,       32'h80);
        chk("bc_req",   32'(mem_req),   32'd1);
        auto_mem = 1'b0; mem_ready = 1'b0;
        branch_addr = 32'h200;
        step();                                   // cycle 4, DROP
        branch_addr = 32'h300;
        chk("dr_busy", 32'(busy), 32'd1);
        step();                                   // cycle 5
        branch_taken = 1'b0; branch_addr = 32'h0; mem_ready = 1'b1;
        chk("dr_hold",  mem_addr,       32'h80);
        chk("dr_valid", 32'(valid_out), 32'd0);
        step();                                   // cycle 6
        auto_mem = 1'b1;
        chk("dr_addr", mem_addr,     32'h300);
        chk("dr_req",  32'(mem_req), 32'd1);
        step();                                   // cycle 7
        chk("dr_pc",    pc_out,      32'h304);
        chk("dr_instr", instruction, 32'hA5A5_0300);
        auto_mem = 1'b0; mem_ready = 1'b0;
        branch_taken = 1'b1; branch_addr = 32'h400;
        step();                                   // cycle 8, DROP at 0x304
        branch_addr = 32'h500; mem_ready = 1'b1;
        step();                                   // cycle 9
        branch_taken = 1'b0; branch_addr = 32'h0; mem_ready = 1'b0;
        chk("drc_addr",  mem_addr,       32'h500);
        chk("drc_valid", 32'(valid_out), 32'd0);
        chk("drc_busy",  32'(busy),      32'd1);

        // ---------------- PC wrap, then reset mid-request ----------------
        do_reset();
        auto_mem = 1'b1; wait_n = 0;
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        step();                                   // cycle 1
        branch_taken = 1'b0; branch_addr = 32'h0;
        chk("wr_addr0", mem_addr, 32'hFFFF_FFFC);
        step();                                   // cycle 2
        chk("wr_valid", 32'(valid_out), 32'd1);
        chk("wr_pc",    pc_out,         32'h0);
        chk("wr_instr", instruction,    32'h5A5A_FFFC);
        chk("wr_addr1", mem_addr,       32'h0);
        step();                                   // cycle 3
        chk("wr_addr2", mem_addr, 32'h4);
        wait_n = 3;
        step(); step();                           // cycle 5, request pending
        chk("mr_pending", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();                                   // cycle 6
        rst = 1'b0; wcnt = 0;
        chk("mr_valid", 32'(valid_out), 32'd0);
        chk("mr_req",   32'(mem_req),   32'd0);
        chk("mr_busy",  32'(busy),      32'd0);
        chk("mr_pc",    pc_out,         32'h0);
        chk("mr_instr", instruction,    32'h0);
        step();                                   // cycle 7
        chk("mr_req2",  32'(mem_req), 32'd1);
        chk("mr_addr2", mem_addr,     32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
